intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_if.sv | 25 ++
 rtl/intr_ctrl.sv | 129 ++++++++++++
 tb/tb_intr_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intr_if.sv
// Bus bundle between the interrupt controller, the peripherals and the CPU.
// slave = controller side, master = CPU/peripheral side.
interface intr_if;
  logic [7:0] intr_in;
  logic       mask_we;
  logic [7:0] mask_in;
  logic [9:0] pc_in;
  logic       intr_ack;
  logic       intr_ret;
  logic       intr_pend;
  logic [7:0] intr_selec;
  logic [9:0] ret_dir;
  logic [7:0] mask_out;
  logic [2:0] depth;

  modport slave (
    input  intr_in, mask_in, mask_we, pc_in, intr_ack, intr_ret,
    output intr_pend, intr_selec, ret_dir, mask_out, depth
  );

  modport master (
    output intr_in, mask_in, mask_we, pc_in, intr_ack, intr_ret,
    input  intr_pend, intr_selec, ret_dir, mask_out, depth
  );
endinterface

// File: rtl/intr_ctrl.sv
// Nested priority interrupt controller with return-address stack (bit 0 = highest priority).
// Define INTR_EDGE_EN for rising-edge capture of requests; default is level mode.
module intr_ctrl #(
  parameter int STACK_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  intr_if.slave bus
);

  // state   | meaning
  // IDLE    | depth 0, nothing requested
  // REQUEST | intr_pend high, sel held until ack
  // SERVICE | depth > 0, no request outstanding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [2:0] DEPTH_MAX = 3'(STACK_DEPTH);

  state_t     state, state_nxt;
  logic [7:0] pend, pend_nxt;
  logic [7:0] isr, isr_nxt;
  logic [7:0] sel, sel_nxt;
  logic [7:0] mask;
  logic [2:0] depth, depth_nxt;
  logic       push;
  logic [9:0] stack [STACK_DEPTH];
  logic [9:0] top;
  logic [7:0] isr_low, limit, elig, winner;

  // Only sources of strictly higher priority than the innermost active one may preempt.
  always_comb begin
    isr_low = isr & (~isr + 8'd1);
    limit   = (isr == 8'h00) ? 8'hFF : (isr_low - 8'd1);
    elig    = pend & mask & ~isr & limit;
    winner  = elig & (~elig + 8'd1);
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    isr_nxt   = isr;
    depth_nxt = depth;
    push      = 1'b0;
    case (state)
      REQUEST: begin
        if (bus.intr_ack) begin
          push      = 1'b1;
          isr_nxt   = isr | sel;
          depth_nxt = depth + 3'd1;
          state_nxt = SERVICE;
        end else if (bus.intr_ret && (depth != 3'd0)) begin
          isr_nxt   = isr & ~isr_low;
          depth_nxt = depth - 3'd1;
        end
      end
      default: begin
        if (bus.intr_ret && (depth != 3'd0)) begin
          isr_nxt   = isr & ~isr_low;
          depth_nxt = depth - 3'd1;
        end
        state_nxt = (depth_nxt == 3'd0) ? IDLE : SERVICE;
        if ((elig != 8'h00) && (depth < DEPTH_MAX)) begin
          state_nxt = REQUEST;
          sel_nxt   = winner;
        end
      end
    endcase
  end

`ifdef INTR_EDGE_EN
  logic [7:0] prev;
  logic [7:0] ack_clr;

  assign ack_clr  = ((state == REQUEST) && bus.intr_ack) ? sel : 8'h00;
  // A new edge wins over the ack clear of the same source so it is not lost.
  assign pend_nxt = (pend & ~ack_clr) | (bus.intr_in & ~prev);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 8'h00;
    else       prev <= bus.intr_in;
  end
`else
  assign pend_nxt = bus.intr_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pend  <= 8'h00;
      isr   <= 8'h00;
      sel   <= 8'h00;
      mask  <= 8'h00;
      depth <= 3'd0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      isr   <= isr_nxt;
      sel   <= sel_nxt;
      depth <= depth_nxt;
      if (bus.mask_we) mask <= bus.mask_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= 10'h000;
    end else if (push) begin
      for (int i = 0; i < STACK_DEPTH; i++)
        if (3'(i) == depth) stack[i] <= bus.pc_in;
    end
  end

  always_comb begin
    top = 10'h000;
    for (int i = 0; i < STACK_DEPTH; i++)
      if ((depth != 3'd0) && (3'(i) == (depth - 3'd1))) top = stack[i];
  end

  assign bus.intr_pend  = (state == REQUEST);
  assign bus.intr_selec = (state == REQUEST) ? sel : 8'h00;
  assign bus.ret_dir    = top;
  assign bus.mask_out   = mask;
  assign bus.depth      = depth;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based priority model.
module tb_intr_ctrl;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  intr_if bus();

  intr_ctrl #(.STACK_DEPTH(SD)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit run_chk = 1'b0;

  // Reference model: pending/in-service as bit sets, return stack as a queue.
  bit [7:0]   m_pend, m_isr, m_mask, m_prev;
  bit         m_req;
  int         m_sel;
  logic [9:0] m_stack [$];

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  function automatic int pick();
    int lim;
    lim = lowest(m_isr);
    for (int i = 0; i < lim; i++)
      if (m_pend[i] && m_mask[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    int win, n;
    if (reset) begin
      m_pend = '0; m_isr = '0; m_mask = '0; m_prev = '0;
      m_req = 1'b0; m_sel = 0;
      m_stack.delete();
    end else begin
      win = pick();
      n = m_stack.size();
      if (m_req) begin
        if (bus.intr_ack) begin
          m_stack.push_back(bus.pc_in);
          m_isr[m_sel] = 1'b1;
          m_pend[m_sel] = 1'b0;
          m_req = 1'b0;
        end else if (bus.intr_ret && n > 0) begin
          void'(m_stack.pop_back());
          m_isr[lowest(m_isr)] = 1'b0;
        end
      end else begin
        if (bus.intr_ret && n > 0) begin
          void'(m_stack.pop_back());
          m_isr[lowest(m_isr)] = 1'b0;
        end
        if (win >= 0 && n < SD) begin
          m_req = 1'b1;
          m_sel = win;
        end
      end
`ifdef INTR_EDGE_EN
      m_pend = m_pend | (bus.intr_in & ~m_prev);
`else
      m_pend = bus.intr_in;
`endif
      m_prev = bus.intr_in;
      if (bus.mask_we) m_mask = bus.mask_in;
    end
  end

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  bit [7:0]   e_sel;
  logic [9:0] e_ret;
  always @(negedge clk) begin
    if (run_chk) begin
      e_sel = m_req ? (8'h01 << m_sel) : 8'h00;
      e_ret = (m_stack.size() > 0) ? m_stack[$] : 10'h000;
      chk("m_intr_pend", 10'(bus.intr_pend), 10'(m_req));
      chk("m_intr_selec", 10'(bus.intr_selec), 10'(e_sel));
      chk("m_ret_dir", bus.ret_dir, e_ret);
      chk("m_mask_out", 10'(bus.mask_out), 10'(m_mask));
      chk("m_depth", 10'(bus.depth), 10'(m_stack.size()));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.intr_in = 8'h00; bus.mask_we = 1'b0; bus.mask_in = 8'h00;
    bus.pc_in = 10'h000; bus.intr_ack = 1'b0; bus.intr_ret = 1'b0;
  endtask

  task automatic restart();
    @(negedge clk);
    #2 reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    #2 reset = 1'b0;
    bus.mask_we = 1'b1; bus.mask_in = 8'hFF;
    @(negedge clk);
    bus.mask_we = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pend"}, 10'(bus.intr_pend), 10'h0);
    chk({tag, "_selec"}, 10'(bus.intr_selec), 10'h0);
    chk({tag, "_ret"}, bus.ret_dir, 10'h0);
    chk({tag, "_mask"}, 10'(bus.mask_out), 10'h0);
    chk({tag, "_depth"}, 10'(bus.depth), 10'h0);
  endtask

  initial begin
    bit saw;
    bit exp_rereq;
    clear_inputs();
    #1 reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    run_chk = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;

    // Basic request, latency and acknowledge
    restart();
    chk("mask_ff", 10'(bus.mask_out), 10'h0FF);
    bus.intr_in = 8'h28;
    step();
    chk("lat_pend0", 10'(bus.intr_pend), 10'h0);
    step();
    chk("s1_pend", 10'(bus.intr_pend), 10'h1);
    chk("s1_selec", 10'(bus.intr_selec), 10'h008);
    bus.intr_ack = 1'b1; bus.pc_in = 10'h045;
    step();
    bus.intr_ack = 1'b0;
    chk("s1_depth", 10'(bus.depth), 10'h1);
    chk("s1_ret", bus.ret_dir, 10'h045);
    chk("s1_pend_low", 10'(bus.intr_pend), 10'h0);
    chk("model_depth", 10'(m_stack.size()), 10'h1);

    // Preemption by higher priority source, then return
    bus.intr_in = 8'h2A;
    step(2);
    chk("s2_selec", 10'(bus.intr_selec), 10'h002);
    bus.intr_ack = 1'b1; bus.pc_in = 10'h101; bus.intr_in = 8'h28;
    step();
    bus.intr_ack = 1'b0;
    chk("s2_depth", 10'(bus.depth), 10'h2);
    chk("s2_ret", bus.ret_dir, 10'h101);
    bus.intr_ret = 1'b1;
    step();
    bus.intr_ret = 1'b0;
    chk("s2_ret_pop", bus.ret_dir, 10'h045);
    chk("s2_depth_pop", 10'(bus.depth), 10'h1);

    // Lower priority source blocked until return
    restart();
    bus.intr_in = 8'h02;
    step(2);
    chk("s3_selec", 10'(bus.intr_selec), 10'h002);
    bus.intr_ack = 1'b1; bus.pc_in = 10'h0AA; bus.intr_in = 8'h20;
    step();
    bus.intr_ack = 1'b0;
    chk("s3_depth", 10'(bus.depth), 10'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s3_blocked", 10'(bus.intr_pend), 10'h0);
    end
    bus.intr_ret = 1'b1;
    step();
    bus.intr_ret = 1'b0;
    chk("s3_ret_cycle", 10'(bus.intr_pend), 10'h0);
    chk("s3_depth0", 10'(bus.depth), 10'h0);
    step();
    chk("s3_pend", 10'(bus.intr_pend), 10'h1);
    chk("s3_selec5", 10'(bus.intr_selec), 10'h020);
    bus.intr_ack = 1'b1; bus.pc_in = 10'h0BB; bus.intr_in = 8'h00;
    step();
    bus.intr_ack = 1'b0;
    chk("s3_ret_bb", bus.ret_dir, 10'h0BB);

    // Full stack blocks new requests
    restart();
    for (int s = 7; s >= 4; s--) begin
      bus.intr_in = 8'h01 << s;
      step(2);
      chk("s4_nest_sel", 10'(bus.intr_selec), 10'(8'h01 << s));
      bus.intr_ack = 1'b1; bus.pc_in = 10'(s);
      step();
      bus.intr_ack = 1'b0;
    end
    chk("s4_full", 10'(bus.depth), 10'(SD));
    bus.intr_in = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s4_blocked", 10'(bus.intr_pend), 10'h0);
    end
    bus.intr_ret = 1'b1;
    step();
    bus.intr_ret = 1'b0;
    chk("s4_after_ret", 10'(bus.intr_pend), 10'h0);
    chk("s4_depth3", 10'(bus.depth), 10'h3);
    chk("s4_ret5", bus.ret_dir, 10'h005);
    step();
    chk("s4_req0", 10'(bus.intr_pend), 10'h1);
    chk("s4_sel0", 10'(bus.intr_selec), 10'h001);

    // Mask write does not cancel a latched request; reset clears at once
    bus.mask_we = 1'b1; bus.mask_in = 8'h00;
    step();
    bus.mask_we = 1'b0;
    chk("s5_mask0", 10'(bus.mask_out), 10'h0);
    chk("s5_hold_pend", 10'(bus.intr_pend), 10'h1);
    chk("s5_hold_sel", 10'(bus.intr_selec), 10'h001);
    step();
    chk("s5_hold_sel2", 10'(bus.intr_selec), 10'h001);
    #2 reset = 1'b1;
    #1 check_all_zero("s5_rst");
    step();
    #2 reset = 1'b0;

    // Held level through ack and return
    restart();
    bus.intr_in = 8'h04;
    step(2);
    chk("s6_sel", 10'(bus.intr_selec), 10'h004);
    bus.intr_ack = 1'b1; bus.pc_in = 10'h033;
    step();
    bus.intr_ack = 1'b0;
    chk("s6_depth1", 10'(bus.depth), 10'h1);
    bus.intr_ret = 1'b1;
    step();
    bus.intr_ret = 1'b0;
    chk("s6_depth0", 10'(bus.depth), 10'h0);
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.intr_pend) saw = 1'b1;
    end
`ifdef INTR_EDGE_EN
    exp_rereq = 1'b0;
`else
    exp_rereq = 1'b1;
`endif
    chk("s6_rereq", 10'(saw), 10'(exp_rereq));

    // Randomized traffic
    restart();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 20) bus.intr_in = 8'($urandom & $urandom);
      bus.mask_we = ($urandom_range(0, 99) < 5);
      bus.mask_in = 8'($urandom | $urandom);
      bus.pc_in = 10'($urandom);
      bus.intr_ack = bus.intr_pend ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 5);
      bus.intr_ret = ($urandom_range(0, 99) < 12);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        step();
        #2 reset = 1'b0;
      end else begin
        step();
      end
    end
    clear_inputs();
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
